hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It takes the register fields and opcode produced by the ID-stage decoder and keeps a shadow record of the instructions in EX, MEM and WB. From that record it drives the load-use stall and the ID/EX bubble, plus the EX-stage forwarding selects for both ALU operands. It also keeps a saturating stall counter for debug and performance measurement.

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, ID/EX bubble and EX forwarding for 5-stage MIPS
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [2:0] c_OP_IMM   = 3'b001;

   localparam logic [1:0] c_FWD_RF  = 2'b00;
   localparam logic [1:0] c_FWD_MEM = 2'b10;
   localparam logic [1:0] c_FWD_WB  = 2'b01;

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       w_use_rs;
   logic       w_use_rt;
   logic       w_wr;
   logic       w_ld;
   logic [4:0] w_dst;
   logic       w_wr_nz;
   logic       w_stall;
   logic       w_bubble;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   logic       r_ex_valid;
   logic [4:0] r_ex_dst;
   logic       r_ex_wr;
   logic       r_ex_ld;
   logic [4:0] r_ex_rs;
   logic [4:0] r_ex_rt;
   logic       r_ex_use_rs;
   logic       r_ex_use_rt;

   // Load flag only matters in EX; later stages just carry the write info.
   logic       r_mem_valid;
   logic [4:0] r_mem_dst;
   logic       r_mem_wr;
   logic       r_wb_valid;
   logic [4:0] r_wb_dst;
   logic       r_wb_wr;

   logic [CNT_W-1:0] r_stall_cnt;

   always_comb begin
      w_use_rs = 1'b0;
      w_use_rt = 1'b0;
      w_wr     = 1'b0;
      w_ld     = 1'b0;
      w_dst    = id_rt;
      if (id_opcode == c_OP_RTYPE) begin
         w_use_rs = 1'b1;
         w_use_rt = 1'b1;
         w_wr     = 1'b1;
         w_dst    = id_rd;
      end else if (id_opcode == c_OP_LW) begin
         w_use_rs = 1'b1;
         w_wr     = 1'b1;
         w_ld     = 1'b1;
      end else if ((id_opcode == c_OP_SW) || (id_opcode == c_OP_BEQ)) begin
         w_use_rs = 1'b1;
         w_use_rt = 1'b1;
      end else if (id_opcode[5:3] == c_OP_IMM) begin
         w_use_rs = 1'b1;
         w_wr     = 1'b1;
      end
   end

   // Writes to $0 are dropped here so no stage ever matches on register 0.
   assign w_wr_nz = w_wr && (w_dst != 5'd0);

   assign w_stall = !rst && id_valid && r_ex_valid && r_ex_ld && r_ex_wr &&
                    ((w_use_rs && (r_ex_dst == id_rs)) ||
                     (w_use_rt && (r_ex_dst == id_rt)));

   assign w_bubble = w_stall || !id_valid;

   always_comb begin
      w_fwd_a = c_FWD_RF;
      if (r_ex_use_rs && r_mem_valid && r_mem_wr && (r_mem_dst == r_ex_rs))
         w_fwd_a = c_FWD_MEM;
      else if (r_ex_use_rs && r_wb_valid && r_wb_wr && (r_wb_dst == r_ex_rs))
         w_fwd_a = c_FWD_WB;
   end

   always_comb begin
      w_fwd_b = c_FWD_RF;
      if (r_ex_use_rt && r_mem_valid && r_mem_wr && (r_mem_dst == r_ex_rt))
         w_fwd_b = c_FWD_MEM;
      else if (r_ex_use_rt && r_wb_valid && r_wb_wr && (r_wb_dst == r_ex_rt))
         w_fwd_b = c_FWD_WB;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid  <= 1'b0;
         r_ex_wr     <= 1'b0;
         r_ex_ld     <= 1'b0;
         r_ex_use_rs <= 1'b0;
         r_ex_use_rt <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_wr     <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_wb_valid  <= r_mem_valid;
         r_wb_dst    <= r_mem_dst;
         r_wb_wr     <= r_mem_wr;
         r_mem_valid <= r_ex_valid;
         r_mem_dst   <= r_ex_dst;
         r_mem_wr    <= r_ex_wr;
         if (w_bubble) begin
            r_ex_valid  <= 1'b0;
            r_ex_wr     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
         end else begin
            r_ex_valid  <= 1'b1;
            r_ex_wr     <= w_wr_nz;
            r_ex_ld     <= w_ld;
            r_ex_use_rs <= w_use_rs;
            r_ex_use_rt <= w_use_rt;
         end
         r_ex_dst <= w_dst;
         r_ex_rs  <= id_rs;
         r_ex_rt  <= id_rt;
         if (w_stall && (r_stall_cnt != c_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
   end

   assign pc_we       = !w_stall;
   assign ifid_we     = !w_stall;
   assign idex_bubble = rst || w_bubble;
   assign fwd_a       = rst ? c_FWD_RF : w_fwd_a;
   assign fwd_b       = rst ? c_FWD_RF : w_fwd_b;
   assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
